// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
// Groups the run-control and program-counter signals of the fetch stage.
//   master : drives Start, problem_in, Branch_en, Jump and Halt_instr, and
//            observes PC, problem, Running, Done and Cycle_count
//            (the testbench or the surrounding control logic).
//   slave  : the pc_fetch_ctrl block itself.
// PC_W must match the width of the jump LUT's Jump output.
interface pc_fetch_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [1:0]       problem_in;
  logic             Branch_en;
  logic [PC_W-1:0]  Jump;
  logic             Halt_instr;
  logic [PC_W-1:0]  PC;
  logic [1:0]       problem;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] Cycle_count;

  modport master (
    output Start, problem_in, Branch_en, Jump, Halt_instr,
    input  PC, problem, Running, Done, Cycle_count
  );

  modport slave (
    input  Start, problem_in, Branch_en, Jump, Halt_instr,
    output PC, problem, Running, Done, Cycle_count
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Program counter and run control for one problem run. A rising edge on
// Start (from IDLE or DONE) latches problem_in, clears PC and the cycle
// counter and enters RUN. In RUN the PC advances, takes the LUT Jump target
// on a branch, and the run ends on a halt instruction or when sequential
// fall-through would go past MAX_PC.
// Ports:
//   Clk      : clock, rising edge active
//   Reset_n  : asynchronous active-low reset
//   bus      : pc_fetch_ctrl_if slave (Start, problem_in, Branch_en, Jump,
//              Halt_instr in; PC, problem, Running, Done, Cycle_count out)
module pc_fetch_ctrl #(
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16,
  parameter int MAX_PC = 255
) (
  input  logic           Clk,
  input  logic           Reset_n,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [1:0]       problem_reg, problem_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_q_reg;
  logic             start_edge;
  logic             running, done;

  // Only a 0->1 transition of the Start level launches a run.
  assign start_edge = bus.Start & ~start_q_reg;

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      problem_reg <= '0;
      cnt_reg     <= '0;
      start_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      problem_reg <= problem_next;
      cnt_reg     <= cnt_next;
      start_q_reg <= bus.Start;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    problem_next = problem_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_next   = ST_RUN;
          pc_next      = '0;
          problem_next = bus.problem_in;
          cnt_next     = '0;
        end
      end
      ST_RUN: begin
        // Every RUN edge counts, including the one that leaves RUN;
        // the count sticks at all-ones instead of wrapping.
        if (cnt_reg != {CNT_W{1'b1}}) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // Halt beats branch; a taken branch at MAX_PC keeps the run alive.
        if (bus.Halt_instr) begin
          state_next = ST_DONE;
        end else if (bus.Branch_en) begin
          pc_next = bus.Jump;
        end else if (pc_reg == PC_W'(MAX_PC)) begin
          state_next = ST_DONE;
        end else begin
          pc_next = pc_reg + PC_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded purely from the state register.
  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    case (state_reg)
      ST_RUN:  running = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

  assign bus.PC          = pc_reg;
  assign bus.problem     = problem_reg;
  assign bus.Running     = running;
  assign bus.Done        = done;
  assign bus.Cycle_count = cnt_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
// Table-driven vectors plus hand-written sequences for fall-off-end,
// branch at MAX_PC and asynchronous mid-run reset. Each applied cycle pushes
// its expected outputs to a scoreboard queue, popped and compared one time
// unit after the following rising edge.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst_n;

  pc_fetch_ctrl_if #(.PC_W(8), .CNT_W(16)) bus ();

  pc_fetch_ctrl #(.PC_W(8), .CNT_W(16), .MAX_PC(255)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [1:0]  prob;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        start;
    logic [1:0]  pin;
    logic        br;
    logic [7:0]  jmp;
    logic        halt;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[32];
  int   nv;
  int   total;
  int   bad;
  int   txn;

  task automatic vadd(input logic s, input logic [1:0] pi, input logic br,
                      input logic [7:0] j, input logic h, input logic [7:0] epc,
                      input logic [1:0] epr, input logic er, input logic ed,
                      input logic [15:0] ec);
    vecs[nv].start    = s;
    vecs[nv].pin      = pi;
    vecs[nv].br       = br;
    vecs[nv].jmp      = j;
    vecs[nv].halt     = h;
    vecs[nv].exp.pc   = epc;
    vecs[nv].exp.prob = epr;
    vecs[nv].exp.run  = er;
    vecs[nv].exp.done = ed;
    vecs[nv].exp.cnt  = ec;
    nv++;
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s %s got=%0d want=%0d", nm, fld, act, req);
    end
  endtask

  task automatic check_out(input exp_t e, input string nm);
    cmp(nm, "PC", int'(bus.PC), int'(e.pc));
    cmp(nm, "problem", int'(bus.problem), int'(e.prob));
    cmp(nm, "Running", int'(bus.Running), int'(e.run));
    cmp(nm, "Done", int'(bus.Done), int'(e.done));
    cmp(nm, "Cycle_count", int'(bus.Cycle_count), int'(e.cnt));
    $display("txn %0d %s: PC=%0d problem=%0d Running=%0b Done=%0b Cycle_count=%0d",
             txn, nm, bus.PC, bus.problem, bus.Running, bus.Done, bus.Cycle_count);
    txn++;
  endtask

  // Called at posedge+1: drive inputs, queue expectation, sample after next edge.
  task automatic step(input logic s, input logic [1:0] pi, input logic br,
                      input logic [7:0] j, input logic h, input exp_t e,
                      input string nm);
    exp_t got;
    bus.Start      = s;
    bus.problem_in = pi;
    bus.Branch_en  = br;
    bus.Jump       = j;
    bus.Halt_instr = h;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_out(got, nm);
  endtask

  function automatic exp_t mk(input logic [7:0] pc, input logic [1:0] pr,
                              input logic r, input logic d, input logic [15:0] c);
    exp_t e;
    e.pc = pc; e.prob = pr; e.run = r; e.done = d; e.cnt = c;
    return e;
  endfunction

  initial begin
    total = 0; bad = 0; txn = 0; nv = 0;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.problem_in = 2'd0; bus.Branch_en = 1'b0;
    bus.Jump = 8'd0; bus.Halt_instr = 1'b0;

    // start pin br jmp halt | pc prob run done cnt
    vadd(0, 0, 0, 0,   0,   0,   0, 0, 0, 0);  // idle after reset
    vadd(0, 0, 0, 0,   0,   0,   0, 0, 0, 0);
    vadd(1, 1, 0, 0,   0,   0,   1, 1, 0, 0);  // start problem 1
    vadd(0, 0, 0, 0,   0,   1,   1, 1, 0, 1);
    vadd(0, 0, 0, 0,   0,   2,   1, 1, 0, 2);
    vadd(0, 0, 0, 0,   0,   3,   1, 1, 0, 3);
    vadd(0, 0, 0, 0,   1,   3,   1, 0, 1, 4);  // halt
    vadd(0, 0, 1, 77,  0,   3,   1, 0, 1, 4);  // branch ignored in DONE
    vadd(1, 0, 0, 0,   0,   0,   0, 1, 0, 0);  // start problem 0
    vadd(0, 0, 0, 0,   0,   1,   0, 1, 0, 1);
    vadd(0, 0, 0, 0,   0,   2,   0, 1, 0, 2);
    vadd(0, 0, 0, 0,   0,   3,   0, 1, 0, 3);
    vadd(0, 0, 0, 0,   0,   4,   0, 1, 0, 4);
    vadd(0, 0, 0, 0,   0,   5,   0, 1, 0, 5);
    vadd(0, 0, 1, 110, 0, 110,   0, 1, 0, 6);  // branch
    vadd(0, 0, 0, 0,   0, 111,   0, 1, 0, 7);
    vadd(0, 0, 0, 0,   0, 112,   0, 1, 0, 8);
    vadd(0, 0, 1, 30,  1, 112,   0, 0, 1, 9);  // halt beats branch
    vadd(1, 3, 0, 0,   0,   0,   3, 1, 0, 0);  // start held high from here
    vadd(1, 1, 0, 0,   0,   1,   3, 1, 0, 1);
    vadd(1, 1, 0, 0,   1,   1,   3, 0, 1, 2);
    vadd(1, 2, 0, 0,   0,   1,   3, 0, 1, 2);  // no retrigger
    vadd(0, 2, 0, 0,   0,   1,   3, 0, 1, 2);
    vadd(1, 2, 0, 0,   0,   0,   2, 1, 0, 0);  // fresh edge in DONE
    vadd(0, 0, 0, 0,   0,   1,   2, 1, 0, 1);
    vadd(1, 0, 0, 0,   0,   2,   2, 1, 0, 2);  // edge in RUN ignored
    vadd(0, 0, 0, 0,   1,   2,   2, 0, 1, 3);

    // Reset: outputs must be cleared while Reset_n is low.
    repeat (2) @(posedge clk);
    #1;
    check_out(mk(0, 0, 0, 0, 0), "reset");
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].start, vecs[i].pin, vecs[i].br, vecs[i].jmp, vecs[i].halt,
           vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Fall-off-end: sequential run through to MAX_PC.
    step(1, 1, 0, 0, 0, mk(0, 1, 1, 0, 0), "fall_start");
    for (int i = 1; i <= 255; i++) begin
      step(0, 0, 0, 0, 0, mk(8'(i), 1, 1, 0, 16'(i)), "fall_run");
    end
    step(0, 0, 0, 0, 0, mk(255, 1, 0, 1, 256), "fall_end");

    // Branch taken at MAX_PC keeps running.
    step(1, 2, 0, 0,   0, mk(0,   2, 1, 0, 0), "maxbr_start");
    step(0, 0, 1, 255, 0, mk(255, 2, 1, 0, 1), "maxbr_to255");
    step(0, 0, 1, 10,  0, mk(10,  2, 1, 0, 2), "maxbr_at255");
    step(0, 0, 0, 0,   1, mk(10,  2, 0, 1, 3), "maxbr_halt");

    // Asynchronous reset in the middle of a run at PC=40.
    step(1, 3, 0, 0, 0, mk(0, 3, 1, 0, 0), "arst_start");
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0, 0, mk(8'(i), 3, 1, 0, 16'(i)), "arst_run");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_out(mk(0, 0, 0, 0, 0), "arst_now");
    @(posedge clk);
    #1;
    check_out(mk(0, 0, 0, 0, 0), "arst_hold");
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, mk(0, 1, 1, 0, 0), "arst_restart");
    step(0, 0, 0, 0, 0, mk(1, 1, 1, 0, 1), "arst_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and run-control stage that sits directly downstream of the branch jump-target LUT.
- Latches the active problem select and drives it back to the LUT.
- Holds the 8-bit instruction pointer and consumes the LUT's Jump target when a branch is taken.
- Sequences each problem run from Start to Done and keeps a saturating cycle count for the testbench.

Parameters:
PC_W, 8, instruction pointer width; must match the Jump width.
CNT_W, 16, cycle counter width.
MAX_PC, 255, last legal instruction address; sequential fall-through past it ends the run.

Ports:
Clk  input  1  system clock; rising-edge active.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  level request; only a 0->1 transition starts a run.
problem_in  input  2  problem select sampled on the Start edge.
Branch_en  input  1  branch taken this cycle, from the condition/loop logic.
Jump  input  PC_W  absolute target from the jump LUT.
Halt_instr  input  1  current instruction is halt.
PC  output  PC_W  instruction memory address.
problem  output  2  latched problem select; drives the LUT problem input.
Running  output  1  high while in RUN.
Done  output  1  high while in DONE.
Cycle_count  output  CNT_W  number of RUN cycles in the current or last run.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state=IDLE; PC=0, problem=0, Running=0, Done=0, Cycle_count=0; start_q=0.
  - Takes effect immediately, including mid-run.
- Start edge detect:
  - start_q is a register holding the previous value of Start.
  - Edge = Start & ~start_q.
  - Holding Start high never retriggers a run.
- IDLE or DONE, on an edge:
  - PC<=0, problem<=problem_in, Cycle_count<=0, Done<=0, state<=RUN.
  - Running=1 from the following cycle.
- RUN, per rising edge, in priority order:
  1. Halt_instr=1: state<=DONE, PC holds.
  2. Branch_en=1: PC<=Jump. Jump is used as-is; an out-of-range target is not checked.
  3. PC==MAX_PC: state<=DONE, PC holds (fall-off-end).
  4. Otherwise: PC<=PC+1.
- Cycle_count in RUN:
  - Increments on every RUN edge, including the edge that exits to DONE.
  - Saturates at all-ones and never wraps.
- Start edge while in RUN is ignored. problem is stable for the whole run.
- Branch_en and Halt_instr are ignored outside RUN.
- Outputs are decoded from registered state:
  - Running=(state==RUN); Done=(state==DONE).
  - Both are registered outputs with no combinational path from inputs.
- Latency:
  - Jump to PC: one clock.
  - Halt to Done: one clock.
  - Start edge to Running: one clock.
- Simultaneous Halt_instr and Branch_en: halt wins and PC does not take Jump.
- Branch_en at PC==MAX_PC: the branch wins and the run continues.
- The FSM has three states (IDLE, RUN, DONE); the state encoding is an implementation choice. Any unused encoding returns to IDLE.

Test Plan:
1. Reset_n low for 2 cycles, then high, with Start=0 -> PC=0, problem=0, Running=0, Done=0, Cycle_count=0; state stays IDLE.
2. problem_in=1, Start pulse; 3 RUN cycles with no branch; then Halt_instr=1 for one cycle -> PC goes 0,1,2,3 then holds at 3; problem=1; Done=1 one cycle after the halt; Cycle_count=4.
3. problem_in=0, in RUN at PC=5 assert Branch_en with Jump=110 -> PC=110 next cycle, then 111, 112; a simultaneous Halt_instr+Branch_en at PC=112 (Jump=30) -> PC stays 112, Done=1.
4. Start held high across the whole run and into DONE -> exactly one run. Dropping Start to 0 and raising it again in DONE with problem_in=2 -> PC=0, problem=2, Cycle_count=0, Running=1.
5. Run with no branches from PC=0 -> at PC=255 the next edge enters DONE with PC=255 held and Cycle_count=256.
6. Reset_n asserted mid-run at PC=40, asynchronously between clock edges -> all outputs return to reset values immediately; a Start edge after release begins a fresh run from PC=0.
